mips_instr_encoder: RTL and testbench
=====================================

# mips_instr_encoder

Issue-side companion to the DE0 single-cycle MIPS core. It accepts an operation selector and register/immediate fields over a valid/ready request handshake, and rejects illegal destinations before issue. Legal requests are encoded into a 32-bit R- or I-type instruction word and driven onto the core's instruction input. After a configurable settle time it captures the core's combinational result and returns it over a valid/ready response handshake.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles instr_out is held before result_in is sampled; legal range 1..255.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- op_sel  in  4  0 add, 1 sub, 2 and, 3 or, 4 sltu, 5 sll, 6 srl, 7 sra, 8 addi, 9 addiu, 10 slti, 11 andi, 12 ori, 13 lui; 14–15 illegal.
- rs, rt, rd  in  5 each  register fields.
- shamt  in  5  shift amount; R-type only.
- imm16  in  16  immediate; I-type only.
- instr_out  out  32  instruction word to the core.
- result_in  in  32  core result.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- result_out  out  32  captured result; 0 on error.
- err  out  1  response is an error.
- err_code  out  2  00 none, 01 illegal op_sel, 10 destination $zero, 11 destination $k0/$k1.
- issue_count  out  16  count of successfully issued instructions.

## Operation
- FSM states: IDLE, ENCODE, DRIVE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all fields and go to ENCODE.
- ENCODE (1 cycle):
  - Build the word.
  - Determine the destination: rd for op_sel 0–7, rt for op_sel 8–13.
  - Check errors in priority order: illegal op_sel, then destination 0, then destination 26/27.
  - On error: set err/err_code, result_out=0, go to RESP. instr_out is unchanged.
  - Otherwise: load instr_out, load the settle counter with SETTLE_CYCLES, go to DRIVE.
- R-type encoding: {6'b000000, rs, rt, rd, shamt, funct}. funct: add 0x20, sub 0x22, and 0x24, or 0x25, sltu 0x2B, sll 0x00, srl 0x02, sra 0x03. All fields pass through verbatim.
- I-type encoding: {opcode, rs, rt, imm16}. opcode: addi 0x08, addiu 0x09, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F. For lui, the rs field is forced to 0.
- DRIVE:
  - Counter decrements each cycle.
  - On the cycle it reads 1: sample result_in into result_out, clear err, increment issue_count (wraps 0xFFFF→0), go to RESP.
- RESP:
  - resp_valid=1; result_out, err and err_code held stable.
  - On resp_ready, go to IDLE.
- instr_out always holds the last legally issued word. It never changes outside the ENCODE→DRIVE transition.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, resp_valid=0.
  - instr_out=32'h3C01_0000 (lui $1,0, a legal non-$zero destination).
  - result_out=0, err=0, err_code=00, issue_count=0.
- Legal request latency: the response is valid 2+SETTLE_CYCLES cycles after the accepting edge (accept, ENCODE, SETTLE_CYCLES of DRIVE).
- Error latency: resp_valid is asserted 2 cycles after accept.
- req_ready is low from ENCODE through RESP.
- A request asserted while req_ready=0 is not accepted and must be held by the source.
- resp_valid and resp_ready high on the same edge completes the transfer. req_ready is high the next cycle, so back-to-back requests are spaced by at least one IDLE cycle.
- result_in is sampled only on the final DRIVE edge; changes at any other time are ignored.
- Reset asserted mid-operation (ENCODE, DRIVE or RESP) aborts immediately to reset values, including instr_out. The pending request and response are lost.

## Test plan
- add, rs=1, rt=2, rd=3, shamt=0 -> instr_out=32'h0022_1820; with result_in=5, result_out=5, err=0, resp_valid 4 cycles after accept (SETTLE_CYCLES=2); issue_count=1.
- addi, rs=1, rt=5, imm16=16'hFFFF -> instr_out=32'h2025_FFFF; result_in captured only on the final DRIVE edge (toggle it earlier to prove this).
- lui, rs=7, rt=4, imm16=16'h1234 -> instr_out=32'h3C04_1234 (rs forced 0).
- Errors:
  - sub with rd=0 -> err=1, err_code=10.
  - ori with rt=27 -> err_code=11.
  - op_sel=14 -> err_code=01.
  - For all three: resp_valid 2 cycles after accept, instr_out and issue_count unchanged.
- Hold resp_ready=0 for 5 cycles -> resp_valid and result_out stable, req_ready=0; the request presented meanwhile is accepted only after the response completes.
- Assert reset during DRIVE -> all outputs return to reset values asynchronously (instr_out=32'h3C01_0000); the next request processes normally.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// Issue-side encoder for the single-cycle MIPS core.
// A request is latched and encoded into an R- or I-type word. Illegal
// destinations are rejected without touching the core. Legal words are
// driven to the core, its result is sampled after SETTLE_CYCLES, and the
// result is returned over a valid/ready response handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | req_ready high, waiting for a request
// ENCODE | build word, pick destination, check for errors
// DRIVE  | instr_out held while the core settles; down-counter running
// RESP   | response presented until resp_ready
module mips_instr_encoder #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm16,
    output logic [31:0] instr_out,
    input  logic [31:0] result_in,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] result_out,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] issue_count
);

    typedef enum logic [1:0] {IDLE, ENCODE, DRIVE, RESP} state_t;

    localparam logic [31:0] RESET_WORD = 32'h3C01_0000;

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [4:0]  rs_q, rt_q, rd_q, shamt_q;
    logic [15:0] imm_q;
    logic [7:0]  settle_cnt;

    logic [5:0]  funct, opcode;
    logic [4:0]  dest;
    logic [31:0] word;
    logic [1:0]  enc_code;

    // Word construction and destination checking from the latched request
    always_comb begin
        funct  = 6'h00;
        opcode = 6'h00;
        case (op_q)
            4'd0:    funct  = 6'h20;
            4'd1:    funct  = 6'h22;
            4'd2:    funct  = 6'h24;
            4'd3:    funct  = 6'h25;
            4'd4:    funct  = 6'h2B;
            4'd5:    funct  = 6'h00;
            4'd6:    funct  = 6'h02;
            4'd7:    funct  = 6'h03;
            4'd8:    opcode = 6'h08;
            4'd9:    opcode = 6'h09;
            4'd10:   opcode = 6'h0A;
            4'd11:   opcode = 6'h0C;
            4'd12:   opcode = 6'h0D;
            4'd13:   opcode = 6'h0F;
            default: opcode = 6'h00;
        endcase

        if (!op_q[3]) begin
            dest = rd_q;
            word = {6'b000000, rs_q, rt_q, rd_q, shamt_q, funct};
        end else begin
            dest = rt_q;
            // lui ignores rs; forcing it to zero keeps the word canonical
            word = {opcode, (op_q == 4'd13) ? 5'd0 : rs_q, rt_q, imm_q};
        end

        if (op_q > 4'd13)
            enc_code = 2'b01;
        else if (dest == 5'd0)
            enc_code = 2'b10;
        else if (dest == 5'd26 || dest == 5'd27)
            enc_code = 2'b11;
        else
            enc_code = 2'b00;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = ENCODE;
            end
            ENCODE:
                state_nxt = (enc_code != 2'b00) ? RESP : DRIVE;
            DRIVE:
                if (settle_cnt == 8'd1)
                    state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default:
                state_nxt = IDLE;
        endcase
    end

    // Request latch, instruction word, settle timer and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= 4'd0;
            rs_q        <= 5'd0;
            rt_q        <= 5'd0;
            rd_q        <= 5'd0;
            shamt_q     <= 5'd0;
            imm_q       <= 16'd0;
            instr_out   <= RESET_WORD;
            settle_cnt  <= 8'd0;
            result_out  <= 32'd0;
            err         <= 1'b0;
            err_code    <= 2'b00;
            issue_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= op_sel;
                        rs_q    <= rs;
                        rt_q    <= rt;
                        rd_q    <= rd;
                        shamt_q <= shamt;
                        imm_q   <= imm16;
                    end
                end
                ENCODE: begin
                    if (enc_code != 2'b00) begin
                        err        <= 1'b1;
                        err_code   <= enc_code;
                        result_out <= 32'd0;
                    end else begin
                        instr_out  <= word;
                        settle_cnt <= 8'(SETTLE_CYCLES);
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt - 8'd1;
                    if (settle_cnt == 8'd1) begin
                        result_out  <= result_in;
                        err         <= 1'b0;
                        err_code    <= 2'b00;
                        issue_count <= issue_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized scoreboard bench for mips_instr_encoder.
module tb_mips_instr_encoder;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  op_sel = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0] imm16 = '0;
    logic [31:0] instr_out;
    logic [31:0] result_in = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] result_out;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] issue_count;

    mips_instr_encoder #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16),
        .instr_out(instr_out), .result_in(result_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .result_out(result_out), .err(err), .err_code(err_code),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] result;
        logic        err;
        logic [1:0]  code;
        logic [31:0] instr;
        logic [15:0] cnt;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_instr = 32'h3C01_0000;
    logic [15:0] m_cnt = 16'd0;
    logic        stall_req = 1'b0;

    logic [5:0] funct_tab [0:7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2B, 6'h00, 6'h02, 6'h03};
    logic [5:0] opc_tab   [0:5] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [1:0] ref_code(input logic [3:0] op, input logic [4:0] t, input logic [4:0] d);
        logic [4:0] dst;
        dst = (op < 4'd8) ? d : t;
        if (op > 4'd13) return 2'b01;
        if (dst == 5'd0) return 2'b10;
        if (dst == 5'd26 || dst == 5'd27) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_word(input logic [3:0] op, input logic [4:0] s,
            input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh, input logic [15:0] imm);
        if (op < 4'd8)
            return {6'd0, s, t, d, sh, funct_tab[op[2:0]]};
        return {opc_tab[int'(op) - 8], (op == 4'd13) ? 5'd0 : s, t, imm};
    endfunction

    // Present a request, wait for acceptance, and return the accept cycle
    task automatic present(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
            input logic [4:0] d, input logic [4:0] sh, input logic [15:0] imm, output int acc);
        op_sel = op; rs = s; rt = t; rd = d; shamt = sh; imm16 = imm;
        req_valid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (req_ready) break;
            if (n > 300) begin
                $display("FAIL req_ready timeout: got 0 want 1");
                $fatal(1, "request never accepted");
            end
        end
        acc = cyc + 1;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
            input logic [4:0] d, input logic [4:0] sh, input logic [15:0] imm, input logic [31:0] good);
        int   acc;
        exp_t e;
        present(op, s, t, d, sh, imm, acc);
        check("accept with response pending", exp_q.size(), 0);
        e.code = ref_code(op, t, d);
        e.err  = (e.code != 2'b00);
        if (!e.err) begin
            m_instr = ref_word(op, s, t, d, sh, imm);
            m_cnt   = m_cnt + 16'd1;
        end
        e.result = e.err ? 32'd0 : good;
        e.instr  = m_instr;
        e.cnt    = m_cnt;
        e.acc    = acc;
        e.lat    = e.err ? 2 : 2 + S;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        op_sel = 4'($urandom); rd = 5'($urandom); rt = 5'($urandom);
        // Only the value present at the final DRIVE edge may be captured
        result_in = $urandom;
        for (int i = 0; i < S; i++) begin
            @(posedge clk); #1;
            result_in = (i == S - 1) ? good : $urandom;
        end
        @(posedge clk); #1;
        result_in = $urandom;
    endtask

    task automatic drain();
        for (int n = 0; exp_q.size() != 0; n++) begin
            @(posedge clk);
            if (n > 500) begin
                $display("FAIL drain timeout: got %0d pending want 0", exp_q.size());
                fails++;
                tests++;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " instr_out"}, instr_out, 32'h3C01_0000);
        check({tag, " req_ready"}, req_ready, 1);
        check({tag, " resp_valid"}, resp_valid, 0);
        check({tag, " result_out"}, result_out, 0);
        check({tag, " err"}, err, 0);
        check({tag, " err_code"}, err_code, 0);
        check({tag, " issue_count"}, issue_count, 0);
    endtask

    // Consumer: mostly ready, with an optional 5-cycle stall on a response
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_req && resp_valid) begin
                resp_ready = 1'b0;
                stall_req  = 1'b0;
                repeat (5) @(posedge clk);
                #1;
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: stability while stalled, then scoreboard compare on transfer
    logic        seen = 1'b0;
    int          first_cyc;
    logic [31:0] s_res;
    logic [2:0]  s_err;
    exp_t        got_e;
    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            check("req_ready during resp", req_ready, 0);
            if (!seen) begin
                seen = 1'b1;
                first_cyc = cyc + 1;
                s_res = result_out;
                s_err = {err, err_code};
            end else begin
                check("stable result_out", result_out, s_res);
                check("stable err", {err, err_code}, s_err);
            end
            if (resp_ready) begin
                seen = 1'b0;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected response: got result %h want none", result_out);
                end else begin
                    got_e = exp_q.pop_front();
                    check("result_out", result_out, got_e.result);
                    check("err", err, got_e.err);
                    check("err_code", err_code, got_e.code);
                    check("instr_out", instr_out, got_e.instr);
                    check("issue_count", issue_count, got_e.cnt);
                    check("latency", first_cyc - got_e.acc, got_e.lat);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int        acc;
        logic [3:0] op;
        logic [4:0] pick;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 32'd5);
        drain();
        check("add word", instr_out, 32'h0022_1820);
        check("add issue_count", issue_count, 16'd1);

        send(4'd8, 5'd1, 5'd5, 5'd0, 5'd0, 16'hFFFF, 32'hCAFE_0001);
        drain();
        check("addi word", instr_out, 32'h2025_FFFF);

        send(4'd13, 5'd7, 5'd4, 5'd0, 5'd0, 16'h1234, 32'h1234_0000);
        drain();
        check("lui word", instr_out, 32'h3C04_1234);

        send(4'd1, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0000, 32'h1111_1111);
        send(4'd12, 5'd3, 5'd27, 5'd9, 5'd0, 16'h00F0, 32'h2222_2222);
        send(4'd14, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0000, 32'h3333_3333);
        drain();
        check("word after errors", instr_out, 32'h3C04_1234);
        check("count after errors", issue_count, 16'd3);

        stall_req = 1'b1;
        send(4'd3, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0000, 32'h0BAD_F00D);
        send(4'd5, 5'd0, 5'd9, 5'd11, 5'd4, 16'h0000, 32'h0000_0090);
        drain();

        // Reset during DRIVE aborts the operation
        present(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, acc);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_reset_values("mid-drive reset");
        m_instr = 32'h3C01_0000;
        m_cnt   = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        send(4'd2, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0000, 32'h0F0F_0F0F);
        drain();
        check("post-reset count", issue_count, 16'd1);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            rd = 5'($urandom);
            rt = 5'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       pick = 5'd0;
                    1:       pick = 5'd26;
                    default: pick = 5'd27;
                endcase
                rd = pick;
                rt = pick;
            end
            send(op, 5'($urandom), rt, rd, 5'($urandom), 16'($urandom), $urandom);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
